nanci_pe_sched: RTL and testbench
=================================

# nanci_pe_sched

Parametrised mesh processing element for the Nanci sorter, driven per cycle by an external op stream. It holds one {key, data} word and exchanges it with one of four neighbours. In the SORT phase each op is a take, keep-min or keep-max compare-exchange; in the COMPUTE phase it takes or merges duplicate keys. A shared row/column controller issues the ops, and one instance sits at each mesh node.

## Interface
Parameters:
- ADDR_WIDTH, 3: key field width.
- DATA_WIDTH, 3: data field width. W = ADDR_WIDTH+DATA_WIDTH.
- I, 0: node index; the reset key is I[ADDR_WIDTH-1:0].
- INIT_DATA, 0: reset data field.
- SORT_CYCLES, 1: valid ops accepted in SORT before moving to COMPUTE (0 = skip SORT).
- COMPUTE_CYCLES, 1: valid ops accepted in COMPUTE before moving to DONE (0 = skip COMPUTE).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- i_start  in  1  begin a run; honoured in IDLE/DONE only.
- i_load  in  1  load i_load_value into cur; honoured in IDLE/DONE only.
- i_load_value  in  W  {key, data} to load.
- i_op_valid  in  1  i_op is valid this cycle.
- i_op  in  4  {kind[3:2], dir[1:0]}.
- i_PE_l, i_PE_r, i_PE_u, i_PE_d  in  W each  neighbour words.
- i_nb_valid  in  4  {d,u,r,l} neighbour present; edge nodes tie the missing bits to 0.
- o_PE  out  W  registered cur word.
- o_busy  out  1  state is SORT or COMPUTE.
- o_done  out  1  state is DONE.
- o_op_count  out  16  valid ops accepted in the current phase.

## Operation
- Direction encoding: L=0, R=1, U=2, D=3. The selected neighbour is nb = i_PE_dir, with key nb[W-1:DATA_WIDTH].
- FSM states IDLE, SORT, COMPUTE, DONE. Reset enters IDLE.
- IDLE/DONE + i_start: go to SORT (or COMPUTE if SORT_CYCLES=0, or DONE if both are 0) and clear the count.
- i_load and i_start together: the load happens, and so does the transition.
- SORT ops (valid and neighbour present):
  - kind 0 HOLD: no change.
  - kind 1 TAKE: cur <= nb.
  - kind 2 MIN: cur <= nb if key(nb) < key(cur).
  - kind 3 MAX: cur <= nb if key(nb) > key(cur).
  - Keys compare unsigned. Equal keys hold.
- COMPUTE ops (valid and neighbour present):
  - kind 0 HOLD: no change.
  - kind 1 TAKE: cur <= nb.
  - kind 2 ADD: if keys are equal, data <= data + nb.data mod 2^DATA_WIDTH; otherwise hold.
  - kind 3 DEDUP: if keys are equal and dir is L or U, data <= 0; otherwise hold.
- If the selected neighbour is not present, the op is a HOLD but still counts.
- Each valid op in SORT/COMPUTE increments o_op_count. The op that makes count = phase length moves the FSM on and clears the count in the same edge.
- i_op_valid in IDLE/DONE is ignored. i_start while busy is ignored.

## Timing
- Reset values:
  - o_PE = {I, INIT_DATA}.
  - o_busy = 0, o_done = 0, o_op_count = 0.
  - state IDLE.
- Neighbour inputs are sampled combinationally in the cycle of the op. cur updates on the next rising edge, so o_PE shows the result one cycle after the op (latency 1). There is no combinational path from inputs to outputs.
- Simultaneous exchanges between two nodes use pre-edge values, so a MIN/MAX pair swaps correctly in one cycle.
- Reset asserted mid-run forces IDLE and the reset word immediately (asynchronously). The first edge after deassert is treated as normal.
- o_op_count saturates at 2^16-1 and does not wrap.

## Structure
- nanci_pkg holds the op-kind and direction constants, the state enum, and the W helper.
- One combinational sub-module, nanci_pe_alu, takes (phase, kind, dir, cur, nb, nb_present) and returns next_cur. The top module holds the FSM, the counter and the registers.

## Test plan
- ADDR=3, DATA=3, I=0, SORT_CYCLES=1, neighbours l/r/u/d = 000_001/000_010/000_011/000_100. Sequence: reset, start, TAKE U → o_PE = 000_011 one cycle later. Then COMPUTE HOLD → o_done = 1.
- cur = 101_000, MIN from R with 010_111 → o_PE = 010_111. Then MAX from R with 001_000 → holds 010_111. Equal-key MIN holds.
- Two nodes, MIN/MAX paired across a link in one cycle with keys 6 and 2 → the nodes hold 2 and 6 respectively after one edge.
- COMPUTE ADD: cur = 011_110, U = 011_011 → 011_001 (wrap). DEDUP from L with equal key → data 0. DEDUP from R → hold.
- i_nb_valid = 0 for the D neighbour, TAKE D → hold, and o_op_count still increments.
- Assert rst mid-SORT → o_PE = {I, INIT_DATA} and o_busy = 0 before the next edge. i_start after deassert restarts with count 0.

Source files
------------

// File: rtl/nanci_pkg.sv
// Shared constants and types for the Nanci sorter processing element:
// op kinds, neighbour directions, the PE state enum and the word-width helper.
package nanci_pkg;

   // Phases of one PE run.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SORT    = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Op kinds: the same 2-bit code means different things per phase.
   localparam logic [1:0] KIND_HOLD  = 2'd0;
   localparam logic [1:0] KIND_TAKE  = 2'd1;
   localparam logic [1:0] KIND_MIN   = 2'd2;  // SORT phase
   localparam logic [1:0] KIND_MAX   = 2'd3;  // SORT phase
   localparam logic [1:0] KIND_ADD   = 2'd2;  // COMPUTE phase
   localparam logic [1:0] KIND_DEDUP = 2'd3;  // COMPUTE phase

   // Neighbour directions, matching bit positions of i_nb_valid.
   localparam logic [1:0] DIR_L = 2'd0;
   localparam logic [1:0] DIR_R = 2'd1;
   localparam logic [1:0] DIR_U = 2'd2;
   localparam logic [1:0] DIR_D = 2'd3;

   // The op counter saturates here rather than wrapping.
   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   // Width of one {key, data} word.
   function automatic int pe_width(input int addr_width, input int data_width);
      return addr_width + data_width;
   endfunction

endpackage

// File: rtl/nanci_pe_alu.sv
// Combinational next-word logic for one PE: applies a single SORT or COMPUTE
// op against the selected neighbour word and returns the word to store.
module nanci_pe_alu
   import nanci_pkg::*;
#(
   parameter  int ADDR_WIDTH = 3,
   parameter  int DATA_WIDTH = 3,
   localparam int W          = pe_width(ADDR_WIDTH, DATA_WIDTH)
) (
   input  state_t         phase,
   input  logic [1:0]     kind,
   input  logic [1:0]     dir,
   input  logic [W-1:0]   cur,
   input  logic [W-1:0]   nb,
   input  logic           nb_present,
   output logic [W-1:0]   next_cur
);

   logic [ADDR_WIDTH-1:0] cur_key;
   logic [ADDR_WIDTH-1:0] nb_key;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [DATA_WIDTH-1:0] nb_data;
   logic [DATA_WIDTH-1:0] sum_data;
   logic                  keys_equal;

   assign cur_key    = cur[W-1:DATA_WIDTH];
   assign nb_key     = nb[W-1:DATA_WIDTH];
   assign cur_data   = cur[DATA_WIDTH-1:0];
   assign nb_data    = nb[DATA_WIDTH-1:0];
   // Sum is truncated to the data width, giving the modulo-2^DATA_WIDTH merge.
   assign sum_data   = cur_data + nb_data;
   assign keys_equal = (cur_key == nb_key);

   // Select the stored word for this op; an absent neighbour degrades to HOLD.
   always_comb begin
      // NOTE: default assignment first so every path drives next_cur and no latch is inferred.
      next_cur = cur;
      if (nb_present) begin
         if (phase == ST_SORT) begin
            case (kind)
               KIND_TAKE: next_cur = nb;
               KIND_MIN:  if (nb_key < cur_key) next_cur = nb;
               KIND_MAX:  if (nb_key > cur_key) next_cur = nb;
               default:   next_cur = cur;
            endcase
         end else if (phase == ST_COMPUTE) begin
            case (kind)
               KIND_TAKE:  next_cur = nb;
               KIND_ADD:   if (keys_equal) next_cur = {cur_key, sum_data};
               // Only the L/U side of a duplicate pair clears, so one copy survives.
               KIND_DEDUP: if (keys_equal && (dir == DIR_L || dir == DIR_U))
                              next_cur = {cur_key, {DATA_WIDTH{1'b0}}};
               default:    next_cur = cur;
            endcase
         end
      end
   end

endmodule

// File: rtl/nanci_pe_sched.sv
// Nanci mesh processing element: holds one {key, data} word, steps through
// IDLE -> SORT -> COMPUTE -> DONE under an external op stream, and exchanges
// its word with one of four neighbours per accepted op.
module nanci_pe_sched
   import nanci_pkg::*;
#(
   parameter  int ADDR_WIDTH     = 3,
   parameter  int DATA_WIDTH     = 3,
   parameter  int I              = 0,
   parameter  int INIT_DATA      = 0,
   parameter  int SORT_CYCLES    = 1,
   parameter  int COMPUTE_CYCLES = 1,
   localparam int W              = pe_width(ADDR_WIDTH, DATA_WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic          i_load,
   input  logic [W-1:0]  i_load_value,
   input  logic          i_op_valid,
   input  logic [3:0]    i_op,
   input  logic [W-1:0]  i_PE_l,
   input  logic [W-1:0]  i_PE_r,
   input  logic [W-1:0]  i_PE_u,
   input  logic [W-1:0]  i_PE_d,
   input  logic [3:0]    i_nb_valid,
   output logic [W-1:0]  o_PE,
   output logic          o_busy,
   output logic          o_done,
   output logic [15:0]   o_op_count
);

   localparam logic [W-1:0] RESET_WORD = {I[ADDR_WIDTH-1:0], INIT_DATA[DATA_WIDTH-1:0]};

   // Zero-length phases are skipped entirely.
   localparam state_t START_STATE = (SORT_CYCLES > 0)    ? ST_SORT :
                                    (COMPUTE_CYCLES > 0) ? ST_COMPUTE : ST_DONE;
   localparam state_t AFTER_SORT  = (COMPUTE_CYCLES > 0) ? ST_COMPUTE : ST_DONE;

   state_t        state_q, state_d;
   logic [15:0]   count_q, count_d;
   logic [W-1:0]  cur_q, cur_d;

   logic [1:0]    kind;
   logic [1:0]    dir;
   logic [W-1:0]  nb;
   logic          nb_present;
   logic [W-1:0]  alu_next;
   logic [31:0]   count_inc;
   logic          phase_end;

   assign kind       = i_op[3:2];
   assign dir        = i_op[1:0];
   assign nb_present = i_nb_valid[dir];

   // Route the neighbour word named by the op's direction field.
   always_comb begin
      nb = i_PE_l;
      case (dir)
         DIR_L:   nb = i_PE_l;
         DIR_R:   nb = i_PE_r;
         DIR_U:   nb = i_PE_u;
         DIR_D:   nb = i_PE_d;
         default: nb = i_PE_l;
      endcase
   end

   nanci_pe_alu #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .phase      (state_q),
      .kind       (kind),
      .dir        (dir),
      .cur        (cur_q),
      .nb         (nb),
      .nb_present (nb_present),
      .next_cur   (alu_next)
   );

   // Compared in 32 bits so phase lengths above the counter range never match early.
   assign count_inc = {16'd0, count_q} + 32'd1;
   assign phase_end = (state_q == ST_SORT) ? (count_inc == 32'(SORT_CYCLES))
                                           : (count_inc == 32'(COMPUTE_CYCLES));

   // Next-state, counter and word update for one accepted cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      cur_d   = cur_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Load and start are independent; both may act in the same cycle.
            if (i_load)  cur_d = i_load_value;
            if (i_start) begin
               state_d = START_STATE;
               count_d = '0;
            end
         end
         ST_SORT, ST_COMPUTE: begin
            if (i_op_valid) begin
               cur_d = alu_next;
               if (phase_end) begin
                  state_d = (state_q == ST_SORT) ? AFTER_SORT : ST_DONE;
                  count_d = '0;
               end else if (count_q != COUNT_MAX) begin
                  count_d = count_q + 16'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counter and word registers; reset forces IDLE and the reset word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         cur_q   <= RESET_WORD;
      end else begin
         // NOTE: non-blocking assignments so neighbouring PEs all see pre-edge words in a swap.
         state_q <= state_d;
         count_q <= count_d;
         cur_q   <= cur_d;
      end
   end

   assign o_PE       = cur_q;
   assign o_busy     = (state_q == ST_SORT) || (state_q == ST_COMPUTE);
   assign o_done     = (state_q == ST_DONE);
   assign o_op_count = count_q;

endmodule

// File: tb/tb_nanci_pe_sched.sv
// Self-checking bench for nanci_pe_sched: three instances (a lone node with
// unit phases and a linked pair with longer phases) checked every cycle
// against a behavioural model, plus literal checks of the directed cases.
module tb_nanci_pe_sched;

   typedef struct {
      logic [5:0] cur;
      int         ph;   // 0 idle, 1 sort, 2 compute, 3 done
      int         cnt;
   } model_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        st   [3];
   logic        ld   [3];
   logic [5:0]  ldv  [3];
   logic        ov   [3];
   logic [3:0]  op   [3];
   logic [3:0]  nbv  [3];
   logic [5:0]  nb_l, nb_r, nb_u, nb_d;
   logic [5:0]  pe   [3];
   logic        busy [3];
   logic        done [3];
   logic [15:0] cnt  [3];

   model_t      m [3];
   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          cmp_en = 1'b0;

   localparam logic [5:0] RESET_WORD [3] = '{6'b000_000, 6'b101_011, 6'b010_011};
   localparam int         SORT_LEN   [3] = '{1, 4, 4};
   localparam int         COMP_LEN   [3] = '{1, 6, 6};

   always #5 clk = ~clk;

   nanci_pe_sched #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .I(0), .INIT_DATA(0),
                    .SORT_CYCLES(1), .COMPUTE_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .i_start(st[0]), .i_load(ld[0]), .i_load_value(ldv[0]),
      .i_op_valid(ov[0]), .i_op(op[0]),
      .i_PE_l(nb_l), .i_PE_r(nb_r), .i_PE_u(nb_u), .i_PE_d(nb_d), .i_nb_valid(nbv[0]),
      .o_PE(pe[0]), .o_busy(busy[0]), .o_done(done[0]), .o_op_count(cnt[0]));

   nanci_pe_sched #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .I(5), .INIT_DATA(3),
                    .SORT_CYCLES(4), .COMPUTE_CYCLES(6)) u_a (
      .clk(clk), .rst(rst), .i_start(st[1]), .i_load(ld[1]), .i_load_value(ldv[1]),
      .i_op_valid(ov[1]), .i_op(op[1]),
      .i_PE_l(nb_l), .i_PE_r(pe[2]), .i_PE_u(nb_u), .i_PE_d(nb_d), .i_nb_valid(nbv[1]),
      .o_PE(pe[1]), .o_busy(busy[1]), .o_done(done[1]), .o_op_count(cnt[1]));

   nanci_pe_sched #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .I(2), .INIT_DATA(3),
                    .SORT_CYCLES(4), .COMPUTE_CYCLES(6)) u_b (
      .clk(clk), .rst(rst), .i_start(st[2]), .i_load(ld[2]), .i_load_value(ldv[2]),
      .i_op_valid(ov[2]), .i_op(op[2]),
      .i_PE_l(pe[1]), .i_PE_r(nb_r), .i_PE_u(nb_u), .i_PE_d(nb_d), .i_nb_valid(nbv[2]),
      .o_PE(pe[2]), .o_busy(busy[2]), .o_done(done[2]), .o_op_count(cnt[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // What one node must hold after the next edge, from the op rules alone.
   function automatic model_t predict(input model_t s, input int slen, input int clen,
                                      input logic start, input logic load, input logic [5:0] lv,
                                      input logic valid, input logic [3:0] opc,
                                      input logic [23:0] nbs, input logic [3:0] nbvld);
      model_t     n;
      int         kind, dir, len;
      logic [5:0] w;
      n    = s;
      kind = int'(opc[3:2]);
      dir  = int'(opc[1:0]);
      w    = nbs[dir*6 +: 6];
      if (s.ph == 0 || s.ph == 3) begin
         if (load) n.cur = lv;
         if (start) begin
            n.cnt = 0;
            n.ph  = (slen > 0) ? 1 : ((clen > 0) ? 2 : 3);
         end
      end else if (valid) begin
         if (nbvld[dir]) begin
            if (s.ph == 1) begin
               if (kind == 1 || (kind == 2 && w[5:3] < s.cur[5:3]) ||
                   (kind == 3 && w[5:3] > s.cur[5:3]))
                  n.cur = w;
            end else begin
               if (kind == 1)
                  n.cur = w;
               else if (kind == 2 && w[5:3] == s.cur[5:3])
                  n.cur[2:0] = 3'((int'(s.cur[2:0]) + int'(w[2:0])) % 8);
               else if (kind == 3 && w[5:3] == s.cur[5:3] && (dir == 0 || dir == 2))
                  n.cur[2:0] = 3'b000;
            end
         end
         len = (s.ph == 1) ? slen : clen;
         if (s.cnt + 1 == len) begin
            n.cnt = 0;
            n.ph  = (s.ph == 1 && clen > 0) ? 2 : 3;
         end else begin
            n.cnt = (s.cnt + 1 > 65535) ? 65535 : s.cnt + 1;
         end
      end
      return n;
   endfunction

   function automatic logic [23:0] nbs_of(input int i);
      if (i == 1) return {nb_d, nb_u, m[2].cur, nb_l};
      if (i == 2) return {nb_d, nb_u, nb_r, m[1].cur};
      return {nb_d, nb_u, nb_r, nb_l};
   endfunction

   // One clock: predict every node from current inputs, take the edge, advance the model.
   task automatic step();
      model_t nx [3];
      for (int i = 0; i < 3; i++)
         nx[i] = predict(m[i], SORT_LEN[i], COMP_LEN[i], st[i], ld[i], ldv[i],
                         ov[i], op[i], nbs_of(i), nbv[i]);
      @(posedge clk);
      for (int i = 0; i < 3; i++) m[i] = nx[i];
      #1;
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0;
         ld[i] = 1'b0;
         ov[i] = 1'b0;
      end
   endtask

   task automatic op_on(input int i, input logic [3:0] code);
      ov[i] = 1'b1;
      op[i] = code;
      step();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m[i].cur = RESET_WORD[i];
         m[i].ph  = 0;
         m[i].cnt = 0;
      end
   endtask

   // Assert reset between edges; the model follows at once.
   task automatic reset_assert();
      #2;
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic reset_release();
      @(negedge clk);
      #2;
      rst = 1'b1;
      step();
   endtask

   // Every cycle, away from the rising edge, every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("pe%0d.o_PE", i),       32'(pe[i]),   32'(m[i].cur));
            check($sformatf("pe%0d.o_busy", i),     32'(busy[i]), 32'(m[i].ph == 1 || m[i].ph == 2));
            check($sformatf("pe%0d.o_done", i),     32'(done[i]), 32'(m[i].ph == 3));
            check($sformatf("pe%0d.o_op_count", i), 32'(cnt[i]),  32'(m[i].cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         st[i] = 1'b0; ld[i] = 1'b0; ldv[i] = '0; ov[i] = 1'b0; op[i] = '0; nbv[i] = 4'hF;
      end
      nb_l = 6'b000_001; nb_r = 6'b000_010; nb_u = 6'b000_011; nb_d = 6'b000_100;
      model_reset();
      #1 cmp_en = 1'b1;
      #11;
      check("reset o_PE node0", 32'(pe[0]), 32'h00);
      check("reset o_PE node_a", 32'(pe[1]), 32'(6'b101_011));
      check("reset o_busy", 32'(busy[0]), 32'd0);
      check("reset o_op_count", 32'(cnt[1]), 32'd0);
      rst = 1'b1;
      step();

      // TAKE U, then one COMPUTE HOLD finishes the run.
      st[0] = 1'b1; step();
      op_on(0, 4'b01_10);
      check("take U", 32'(pe[0]), 32'(6'b000_011));
      op_on(0, 4'b00_00);
      check("done after compute", 32'(done[0]), 32'd1);

      // MIN / MAX / equal-key MIN from R.
      ld[0] = 1'b1; ldv[0] = 6'b101_000; st[0] = 1'b1; step();
      nb_r = 6'b010_111; op_on(0, 4'b10_01);
      check("min R smaller", 32'(pe[0]), 32'(6'b010_111));
      op_on(0, 4'b00_00);
      st[0] = 1'b1; step();
      nb_r = 6'b001_000; op_on(0, 4'b11_01);
      check("max R smaller holds", 32'(pe[0]), 32'(6'b010_111));
      op_on(0, 4'b00_00);
      st[0] = 1'b1; step();
      nb_r = 6'b010_000; op_on(0, 4'b10_01);
      check("min R equal key holds", 32'(pe[0]), 32'(6'b010_111));
      op_on(0, 4'b00_00);

      // COMPUTE ADD with wrap, DEDUP from L clears, DEDUP from R holds.
      ld[0] = 1'b1; ldv[0] = 6'b011_110; st[0] = 1'b1; step();
      op_on(0, 4'b00_00);
      nb_u = 6'b011_011; op_on(0, 4'b10_10);
      check("add U wraps", 32'(pe[0]), 32'(6'b011_001));
      st[0] = 1'b1; step();
      op_on(0, 4'b00_00);
      nb_l = 6'b011_111; op_on(0, 4'b11_00);
      check("dedup L clears", 32'(pe[0]), 32'(6'b011_000));
      ld[0] = 1'b1; ldv[0] = 6'b011_101; st[0] = 1'b1; step();
      op_on(0, 4'b00_00);
      nb_r = 6'b011_111; op_on(0, 4'b11_01);
      check("dedup R holds", 32'(pe[0]), 32'(6'b011_101));

      // Linked pair: MIN on one side, MAX on the other, in the same cycle.
      ld[1] = 1'b1; ldv[1] = 6'b110_000; st[1] = 1'b1;
      ld[2] = 1'b1; ldv[2] = 6'b010_101; st[2] = 1'b1;
      step();
      ov[1] = 1'b1; op[1] = 4'b10_01;
      ov[2] = 1'b1; op[2] = 4'b11_00;
      step();
      check("pair min side", 32'(pe[1]), 32'(6'b010_101));
      check("pair max side", 32'(pe[2]), 32'(6'b110_000));
      check("pair count", 32'(cnt[1]), 32'd1);

      // Absent D neighbour: TAKE holds but is counted.
      nbv[1] = 4'b0111; nb_d = 6'b111_111;
      op_on(1, 4'b01_11);
      check("take absent D holds", 32'(pe[1]), 32'(6'b010_101));
      check("absent D still counts", 32'(cnt[1]), 32'd2);
      nbv[1] = 4'hF;

      // Reset mid-SORT acts before the next edge; a fresh start counts from 0.
      reset_assert();
      check("mid reset o_PE", 32'(pe[1]), 32'(6'b101_011));
      check("mid reset o_busy", 32'(busy[1]), 32'd0);
      reset_release();
      st[1] = 1'b1; step();
      check("restart count", 32'(cnt[1]), 32'd0);
      check("restart busy", 32'(busy[1]), 32'd1);

      // Random traffic on all three nodes, with an occasional asynchronous reset.
      for (int k = 0; k < 600; k++) begin
         if (k % 211 == 150) begin
            reset_assert();
            reset_release();
         end
         nb_l = 6'($urandom); nb_r = 6'($urandom);
         nb_u = 6'($urandom); nb_d = 6'($urandom);
         for (int i = 0; i < 3; i++) begin
            st[i]  = ($urandom_range(0, 5) == 0);
            ld[i]  = ($urandom_range(0, 5) == 0);
            ldv[i] = 6'($urandom);
            ov[i]  = ($urandom_range(0, 3) != 0);
            op[i]  = 4'($urandom);
            nbv[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         end
         step();
      end

      @(negedge clk);
      #1;
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
